aurora_lane_sync_ctrl: RTL

AURORA_LANE_SYNC_CTRL -- requirements
Module: aurora_lane_sync_ctrl

---
 rtl/aurora_ctrl_pkg.sv | 18 +
 rtl/aurora_timeout_cnt.sv | 33 +++
 rtl/aurora_lane_sync_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/aurora_ctrl_pkg.sv
// Shared state encoding and default parameters for the Aurora lane bring-up controller.
package aurora_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LANE_RST  = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_UP        = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam int DEF_NUM_LANES    = 8;
    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_SYNC_TIMEOUT = 65536;
    localparam int DEF_MAX_RETRIES  = 4;
    localparam int DEF_LOSS_FILTER  = 8;

endpackage

// File: rtl/aurora_timeout_cnt.sv
// Saturating up-counter with clear-load and a terminal-count flag; reused for the
// lane reset pulse, the blocksync timeout and the loss-of-sync filter.
module aurora_timeout_cnt #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] r_count;

    // Count register: load clears, enable increments up to the terminal value and holds there.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_en && (r_count != TC_VAL)) begin
            r_count <= r_count + WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/aurora_lane_sync_ctrl.sv
// Bring-up supervisor for a bank of Aurora Rx lanes: pulses lane resets, waits for
// blocksync on all masked lanes, retries on timeout and filters transient sync loss.
module aurora_lane_sync_ctrl
    import aurora_ctrl_pkg::*;
#(
    parameter int NUM_LANES    = DEF_NUM_LANES,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int SYNC_TIMEOUT = DEF_SYNC_TIMEOUT,
    parameter int MAX_RETRIES  = DEF_MAX_RETRIES,
    parameter int LOSS_FILTER  = DEF_LOSS_FILTER
) (
    input  logic                                 clk160,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [NUM_LANES-1:0]                 lane_mask,
    input  logic [NUM_LANES-1:0]                 blocksync_in,
    output logic [NUM_LANES-1:0]                 lane_rst,
    output logic [NUM_LANES-1:0]                 lanes_up,
    output logic                                 channel_up,
    output logic                                 fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_count,
    output logic [2:0]                           state_out
);

    localparam int               RC_W   = $clog2(MAX_RETRIES + 1);
    localparam logic [RC_W-1:0]  MAX_RC = RC_W'(MAX_RETRIES);

    state_e                 r_state;
    logic [NUM_LANES-1:0]   r_lane_rst;
    logic [NUM_LANES-1:0]   r_lanes_up;
    logic                   r_channel_up;
    logic                   r_fault;
    logic [RC_W-1:0]        r_retry_count;

    state_e                 w_state_nxt;
    logic [RC_W-1:0]        w_retry_nxt;
    logic [RC_W-1:0]        w_retry_inc;
    logic [NUM_LANES-1:0]   w_masked;
    logic                   w_all_sync;
    logic                   w_rst_done;
    logic                   w_sync_to;
    logic                   w_loss_tc;

    assign w_masked    = blocksync_in & lane_mask;
    // An empty mask never counts as synced, so it can only end in a timeout.
    assign w_all_sync  = (lane_mask != {NUM_LANES{1'b0}}) && (w_masked == lane_mask);
    assign w_retry_inc = (r_retry_count == MAX_RC) ? r_retry_count : (r_retry_count + RC_W'(1));

    aurora_timeout_cnt #(
        .WIDTH    ($clog2(RST_CYCLES + 1)),
        .TERMINAL (RST_CYCLES - 1)
    ) u_rst_cnt (
        .i_clk  (clk160),
        .i_rst  (rst),
        .i_load ((r_state != ST_LANE_RST) || !en),
        .i_en   (r_state == ST_LANE_RST),
        .o_tc   (w_rst_done)
    );

    aurora_timeout_cnt #(
        .WIDTH    ($clog2(SYNC_TIMEOUT + 1)),
        .TERMINAL (SYNC_TIMEOUT - 1)
    ) u_sync_cnt (
        .i_clk  (clk160),
        .i_rst  (rst),
        .i_load ((r_state != ST_WAIT_SYNC) || !en),
        .i_en   (r_state == ST_WAIT_SYNC),
        .o_tc   (w_sync_to)
    );

    // Terminal at LOSS_FILTER-1 so the drop happens on the LOSS_FILTER-th bad clock.
    aurora_timeout_cnt #(
        .WIDTH    ($clog2(LOSS_FILTER + 1)),
        .TERMINAL (LOSS_FILTER - 1)
    ) u_loss_cnt (
        .i_clk  (clk160),
        .i_rst  (rst),
        .i_load ((r_state != ST_UP) || w_all_sync || !en),
        .i_en   (r_state == ST_UP),
        .o_tc   (w_loss_tc)
    );

    // Next-state and next retry count; en low overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry_count;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_retry_nxt = {RC_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_LANE_RST;
                end
                ST_LANE_RST: begin
                    if (w_rst_done) begin
                        w_state_nxt = ST_WAIT_SYNC;
                    end else begin
                        w_state_nxt = ST_LANE_RST;
                    end
                end
                ST_WAIT_SYNC: begin
                    if (w_all_sync) begin
                        w_state_nxt = ST_UP;
                        w_retry_nxt = {RC_W{1'b0}};
                    end else if (w_sync_to) begin
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = (w_retry_inc == MAX_RC) ? ST_FAULT : ST_LANE_RST;
                    end else begin
                        w_state_nxt = ST_WAIT_SYNC;
                    end
                end
                ST_UP: begin
                    w_retry_nxt = {RC_W{1'b0}};
                    if (!w_all_sync && w_loss_tc) begin
                        w_state_nxt = ST_LANE_RST;
                    end else begin
                        w_state_nxt = ST_UP;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_retry_nxt = {RC_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers; outputs are decoded from the next state so they align with state_out.
    always_ff @(posedge clk160) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_retry_count <= {RC_W{1'b0}};
            r_lane_rst    <= {NUM_LANES{1'b1}};
            r_lanes_up    <= {NUM_LANES{1'b0}};
            r_channel_up  <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_retry_count <= w_retry_nxt;
            r_lane_rst    <= ((w_state_nxt == ST_WAIT_SYNC) || (w_state_nxt == ST_UP)) ?
                             {NUM_LANES{1'b0}} : {NUM_LANES{1'b1}};
            r_lanes_up    <= w_masked;
            r_channel_up  <= (w_state_nxt == ST_UP);
            r_fault       <= (w_state_nxt == ST_FAULT);
        end
    end

    assign lane_rst    = r_lane_rst;
    assign lanes_up    = r_lanes_up;
    assign channel_up  = r_channel_up;
    assign fault       = r_fault;
    assign retry_count = r_retry_count;
    assign state_out   = r_state;

endmodule
